// File: rtl/hazard_if.sv
// Hazard controller signal bundle: ID/EX/MEM register info in, forwarding/stall/flush controls out.
interface hazard_if #(
  parameter int unsigned REG_AW = 3
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic              branch_taken;
  logic [1:0]        forward_A;
  logic [1:0]        forward_B;
  logic              stall;
  logic              flush_id;
  logic              flush_ex;
  logic [15:0]       stall_count;
  logic [15:0]       flush_count;

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write, branch_taken,
    output forward_A, forward_B, stall, flush_id, flush_ex,
    output stall_count, flush_count
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write, branch_taken,
    input  forward_A, forward_B, stall, flush_id, flush_ex,
    input  stall_count, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Execute-stage hazard sequencer: registered forwarding selects, load-use stall, multi-cycle branch flush.
// Define HAZARD_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module hazard_controller #(
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ZERO_REG_EN  = 1
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hif
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       load_use;
  logic       stall_c;
  logic       flush_c;
  logic       enter_flush;
  logic [1:0] sel_a, sel_b;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic src_match(input logic used, input logic [REG_AW-1:0] src,
                                     input logic wr, input logic [REG_AW-1:0] rd);
    return used && wr && (src == rd) && ((ZERO_REG_EN == 0) || (rd != '0));
  endfunction

  // EX producer beats MEM producer: it holds the younger value
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src);
    if (src_match(used, src, hif.ex_reg_write, hif.ex_rd))
      return 2'b10;
    else if (src_match(used, src, hif.mem_reg_write, hif.mem_rd))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    load_use = hif.ex_mem_read && hif.ex_reg_write &&
               (src_match(hif.id_use_rs1, hif.id_rs1, 1'b1, hif.ex_rd) ||
                src_match(hif.id_use_rs2, hif.id_rs2, 1'b1, hif.ex_rd));
    sel_a = fwd_sel(hif.id_use_rs1, hif.id_rs1);
    sel_b = fwd_sel(hif.id_use_rs2, hif.id_rs2);
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    enter_flush = 1'b0;
    case (state)
      RUN: begin
        if (hif.branch_taken) begin
          state_n     = FLUSH;
          cnt_n       = FLUSH_INIT;
          enter_flush = 1'b1;
        end else if (load_use) begin
          stall_c = 1'b1;
          state_n = STALL;
        end
      end
      STALL: begin
        if (hif.branch_taken) begin
          state_n     = FLUSH;
          cnt_n       = FLUSH_INIT;
          enter_flush = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (cnt == '0) state_n = RUN;
        else           cnt_n   = cnt - 4'd1;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      fwd_a <= '0;
      fwd_b <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // A bubble (stall) or squashed slot (flush) enters EX with no forwarding
      if (stall_c || flush_c) begin
        fwd_a <= '0;
        fwd_b <= '0;
      end else begin
        fwd_a <= sel_a;
        fwd_b <= sel_b;
      end
    end
  end

  assign hif.forward_A = fwd_a;
  assign hif.forward_B = fwd_b;
  assign hif.stall     = stall_c;
  assign hif.flush_id  = flush_c;
  assign hif.flush_ex  = flush_c;

`ifdef HAZARD_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + 16'd1;
      if (enter_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hif.stall_count = stall_cnt_q;
  assign hif.flush_count = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf     = enter_flush;
  assign hif.stall_count = '0;
  assign hif.flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: vector table plus multi-cycle stall/flush/reset sequences.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_if #(.REG_AW(3)) hif ();

  hazard_controller #(.REG_AW(3), .FLUSH_CYCLES(2), .ZERO_REG_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rs1, rs2;
    logic       u1, u2;
    logic [2:0] ex_rd;
    logic       ex_rw, ex_mr;
    logic [2:0] mem_rd;
    logic       mem_rw;
    logic [1:0] fa, fb;
    logic       st;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
    hif.ex_rd = '0; hif.ex_reg_write = 0; hif.ex_mem_read = 0;
    hif.mem_rd = '0; hif.mem_reg_write = 0; hif.branch_taken = 0;
  endtask

  task automatic apply(input vec_t v);
    hif.id_rs1 = v.rs1; hif.id_rs2 = v.rs2; hif.id_use_rs1 = v.u1; hif.id_use_rs2 = v.u2;
    hif.ex_rd = v.ex_rd; hif.ex_reg_write = v.ex_rw; hif.ex_mem_read = v.ex_mr;
    hif.mem_rd = v.mem_rd; hif.mem_reg_write = v.mem_rw; hif.branch_taken = 0;
  endtask

  task automatic check_flush(input string name, input logic exp);
    check({name, "_flush_id"}, int'(hif.flush_id), int'(exp));
    check({name, "_flush_ex"}, int'(hif.flush_ex), int'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rs1   rs2   u1 u2 ex_rd rw mr mem_rd rw  fa     fb     st
    vecs[0]  = '{3'd3, 3'd4, 1, 1, 3'd3, 1, 0, 3'd6, 1, 2'b10, 2'b00, 0};
    vecs[1]  = '{3'd1, 3'd5, 1, 1, 3'd5, 1, 0, 3'd5, 1, 2'b00, 2'b10, 0};
    vecs[2]  = '{3'd1, 3'd5, 1, 1, 3'd5, 0, 0, 3'd5, 1, 2'b00, 2'b01, 0};
    vecs[3]  = '{3'd1, 3'd0, 1, 1, 3'd0, 1, 0, 3'd0, 1, 2'b00, 2'b00, 0};
    vecs[4]  = '{3'd3, 3'd4, 0, 1, 3'd3, 1, 0, 3'd4, 1, 2'b00, 2'b01, 0};
    vecs[5]  = '{3'd6, 3'd2, 1, 1, 3'd2, 1, 0, 3'd6, 1, 2'b01, 2'b10, 0};
    vecs[6]  = '{3'd7, 3'd7, 1, 1, 3'd7, 1, 0, 3'd7, 1, 2'b10, 2'b10, 0};
    vecs[7]  = '{3'd1, 3'd2, 1, 1, 3'd4, 1, 1, 3'd1, 1, 2'b01, 2'b00, 0};
    vecs[8]  = '{3'd2, 3'd3, 1, 0, 3'd2, 0, 1, 3'd2, 1, 2'b01, 2'b00, 0};
    vecs[9]  = '{3'd0, 3'd5, 1, 0, 3'd0, 1, 1, 3'd3, 1, 2'b00, 2'b00, 0};
    vecs[10] = '{3'd2, 3'd2, 1, 1, 3'd2, 1, 1, 3'd2, 1, 2'b00, 2'b00, 1};

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fwdA", int'(hif.forward_A), 0);
    check("reset_fwdB", int'(hif.forward_B), 0);
    check("reset_stall", int'(hif.stall), 0);
    check_flush("reset", 1'b0);
    check("reset_stall_count", int'(hif.stall_count), 0);
    check("reset_flush_count", int'(hif.flush_count), 0);
    #3 reset = 1'b0;
    step();

    // Vector table: forwarding priority, use bits, zero register, load-use
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_stall", i), int'(hif.stall), int'(vecs[i].st));
      step();
      check($sformatf("vec%0d_fwdA", i), int'(hif.forward_A), int'(vecs[i].fa));
      check($sformatf("vec%0d_fwdB", i), int'(hif.forward_B), int'(vecs[i].fb));
    end
    idle();
    step();

    // Load-use: one stall cycle, bubble in EX, then MEM forward
    hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_rd = 3'd2;
    hif.id_rs2 = 3'd2; hif.id_use_rs2 = 1;
    #1;
    check("lu_stall_hazard", int'(hif.stall), 1);
    step();
    check("lu_bubble_fwdB", int'(hif.forward_B), 0);
    hif.ex_mem_read = 0; hif.ex_reg_write = 0; hif.ex_rd = '0;
    hif.mem_rd = 3'd2; hif.mem_reg_write = 1;
    #1;
    check("lu_stall_one_cycle", int'(hif.stall), 0);
    step();
    check("lu_fwdB_mem", int'(hif.forward_B), 1);
    check("lu_stall_after", int'(hif.stall), 0);
    check("lu_stall_count", int'(hif.stall_count), PERF ? 2 : 0);
    idle();
    step();

    // Branch flush lasting two cycles; branch during flush ignored
    hif.branch_taken = 1;
    #1;
    check_flush("br_cycle0", 1'b0);
    step();
    hif.branch_taken = 1;
    check_flush("br_cycle1", 1'b1);
    step();
    hif.branch_taken = 0;
    check_flush("br_cycle2", 1'b1);
    step();
    check_flush("br_cycle3", 1'b0);
    step();
    check_flush("br_cycle4", 1'b0);
    check("br_flush_count", int'(hif.flush_count), PERF ? 1 : 0);

    // Simultaneous load-use and branch: branch wins, no stall
    hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_rd = 3'd4;
    hif.id_rs1 = 3'd4; hif.id_use_rs1 = 1; hif.branch_taken = 1;
    #1;
    check("sim_stall0", int'(hif.stall), 0);
    step();
    hif.branch_taken = 0;
    #1;
    check("sim_stall1", int'(hif.stall), 0);
    check_flush("sim_cycle1", 1'b1);
    step();
    check("sim_stall2", int'(hif.stall), 0);
    check_flush("sim_cycle2", 1'b1);
    idle();
    step();
    check_flush("sim_cycle3", 1'b0);
    check("sim_flush_count", int'(hif.flush_count), PERF ? 2 : 0);
    check("sim_stall_count", int'(hif.stall_count), PERF ? 2 : 0);

    // Reset mid-flush with nonzero forward select
    hif.ex_rd = 3'd3; hif.ex_reg_write = 1; hif.id_rs1 = 3'd3; hif.id_use_rs1 = 1;
    hif.branch_taken = 1;
    step();
    hif.branch_taken = 0;
    check_flush("rst_pre", 1'b1);
    check("rst_pre_fwdA", int'(hif.forward_A), 2);
    #2 reset = 1'b1;
    #1;
    check_flush("rst_async", 1'b0);
    check("rst_async_fwdA", int'(hif.forward_A), 0);
    check("rst_async_stall", int'(hif.stall), 0);
    check("rst_async_stall_count", int'(hif.stall_count), 0);
    check("rst_async_flush_count", int'(hif.flush_count), 0);
    idle();
    step();
    #2 reset = 1'b0;
    step();
    check_flush("rst_after", 1'b0);
    hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_rd = 3'd5;
    hif.id_rs1 = 3'd5; hif.id_use_rs1 = 1;
    #1;
    check("rst_run_stall", int'(hif.stall), 1);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
